// File: rtl/mul54_pkg.sv
// mul54_pkg: shared constants for the 54x54 DSP multiplier.
// Used by both the multiplier front end and the pp_recombine back end.
// Holds the operand and segment widths, the derived adder widths and the
// shift amounts that place each partial product at its weight.
package mul54_pkg;

  localparam int RADIX = 54;            // operand width
  localparam int A_SEG = 27;            // a-segment width
  localparam int B_SEG = 18;            // b-segment width
  localparam int PP_W  = A_SEG + B_SEG; // partial-product width, 45

  localparam int S_W = PP_W + A_SEG;    // stage-1 sum width, 72
  localparam int T_W = S_W + B_SEG;     // stage-2 sum width, 90
  localparam int P_W = 2 * RADIX;       // product width, 108

  localparam int SH_A  = A_SEG;         // shift of the a[53:27] products
  localparam int SH_B1 = B_SEG;         // shift of the b[35:18] segment
  localparam int SH_B2 = 2 * B_SEG;     // shift of the b[53:36] segment

endpackage

// File: rtl/pp_pipe_slice.sv
// pp_pipe_slice: one elastic valid/ready register slice.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready is combinational
//   in_data  [W]          data captured on in_valid & in_ready
//   out_valid / out_ready downstream handshake; out_valid is the stored valid
//   out_data [W]          registered data
// The slice loads when it is empty or is being drained in the same cycle,
// so a chain of slices streams one item per cycle with no bubbles.
module pp_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         load_s;

  // Ready chains combinationally from the downstream stage.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: load a new item, drain to empty, or hold.
  always_comb begin
    load_s  = in_valid && in_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register with asynchronous reset of valid and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pp_recombine.sv
// pp_recombine: back end of the 54x54 multiplier. Sums the six 45-bit
// partial products of the 2x3 DSP-tile grid into the 108-bit product
// through three elastic adder stages.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   accept handshake for a coherent pp_0..pp_5 set
//   pp_0..pp_2 [PP_W]     a[26:0]  x b[17:0], b[35:18], b[53:36]
//   pp_3..pp_5 [PP_W]     a[53:27] x b[17:0], b[35:18], b[53:36]
//   out_valid / out_ready product handshake
//   product [2*RADIX]     a x b, registered
// Stage 1 folds each a-half pair into s_k, stage 2 merges s_0 and s_1,
// stage 3 adds s_2 at its weight. Latency 3, throughput 1 per cycle.
import mul54_pkg::*;

module pp_recombine #(
  parameter int RADIX = mul54_pkg::RADIX,
  parameter int A_SEG = mul54_pkg::A_SEG,
  parameter int B_SEG = mul54_pkg::B_SEG,
  parameter int PP_W  = mul54_pkg::PP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PP_W-1:0]      pp_0,
  input  logic [PP_W-1:0]      pp_1,
  input  logic [PP_W-1:0]      pp_2,
  input  logic [PP_W-1:0]      pp_3,
  input  logic [PP_W-1:0]      pp_4,
  input  logic [PP_W-1:0]      pp_5,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*RADIX-1:0]   product
);

  localparam int S_W = PP_W + A_SEG;
  localparam int T_W = S_W + B_SEG;
  localparam int P_W = 2 * RADIX;

  logic [S_W-1:0]     s0_s, s1_s, s2_s;
  logic [3*S_W-1:0]   st1_in_s, st1_out_s;
  logic [T_W-1:0]     t_s;
  logic [S_W+T_W-1:0] st2_in_s, st2_out_s;
  logic [P_W-1:0]     st3_in_s;
  logic               st1_valid_s, st2_valid_s;
  logic               st2_ready_s, st3_ready_s;

  // Stage-1 adders: each b-segment column gets its a[53:27] product shifted up.
  always_comb begin
    s0_s     = S_W'(pp_0) + (S_W'(pp_3) << A_SEG);
    s1_s     = S_W'(pp_1) + (S_W'(pp_4) << A_SEG);
    s2_s     = S_W'(pp_2) + (S_W'(pp_5) << A_SEG);
    st1_in_s = {s2_s, s1_s, s0_s};
  end

  pp_pipe_slice #(.W(3*S_W)) u_st1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid),     .in_ready(in_ready),    .in_data(st1_in_s),
    .out_valid(st1_valid_s), .out_ready(st2_ready_s), .out_data(st1_out_s)
  );

  // Stage-2 adder: merge columns 0 and 1; column 2 rides along untouched.
  always_comb begin
    t_s      = T_W'(st1_out_s[S_W-1:0]) + (T_W'(st1_out_s[2*S_W-1:S_W]) << B_SEG);
    st2_in_s = {st1_out_s[3*S_W-1:2*S_W], t_s};
  end

  pp_pipe_slice #(.W(S_W+T_W)) u_st2 (
    .clk(clk), .rst(rst),
    .in_valid(st1_valid_s),  .in_ready(st2_ready_s),  .in_data(st2_in_s),
    .out_valid(st2_valid_s), .out_ready(st3_ready_s), .out_data(st2_out_s)
  );

  // Stage-3 adder: add column 2 at weight 2*B_SEG, wrapping at P_W bits.
  always_comb begin
    st3_in_s = P_W'(st2_out_s[T_W-1:0])
             + (P_W'(st2_out_s[S_W+T_W-1:T_W]) << (2 * B_SEG));
  end

  pp_pipe_slice #(.W(P_W)) u_st3 (
    .clk(clk), .rst(rst),
    .in_valid(st2_valid_s), .in_ready(st3_ready_s), .in_data(st3_in_s),
    .out_valid(out_valid),  .out_ready(out_ready),  .out_data(product)
  );

endmodule
